// File: rtl/minterm_sweep_checker.sv
// Sweeps every input vector of a small combinational function, samples its response and
// compares the observed truth table against EXPECT, reporting pass/fail and the first bad vector.
module minterm_sweep_checker #(
   parameter int unsigned               N_IN   = 4,
   parameter logic [(1 << N_IN) - 1:0]  EXPECT = 16'h9180,
   parameter int unsigned               SETTLE = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       dut_out,
   output logic [N_IN-1:0]            dut_in,
   output logic                       busy,
   output logic                       done,
   output logic                       pass,
   output logic [N_IN:0]              err_count,
   output logic [N_IN-1:0]            first_err_idx,
   output logic                       first_err_vld,
   output logic [(1 << N_IN) - 1:0]   table_out
);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE_W,
      SAMPLE,
      DONE
   } state_t;

   localparam logic [N_IN-1:0] LAST_IDX   = '1;
   localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);
   // With no settle time a freshly driven vector is sampled on the very next edge.
   localparam state_t          LOAD_STATE = (SETTLE == 0) ? SAMPLE : SETTLE_W;

   state_t            state;
   logic [3:0]        wait_cnt;
   logic              mismatch;
   logic [N_IN:0]     err_next;

   // dut_in doubles as the sweep index, so the vector on the wire is always the one being judged.
   assign mismatch = (dut_out != EXPECT[dut_in]);
   assign err_next = err_count + {{N_IN{1'b0}}, mismatch};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         wait_cnt      <= '0;
         dut_in        <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         err_count     <= '0;
         first_err_idx <= '0;
         first_err_vld <= 1'b0;
         table_out     <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state         <= LOAD_STATE;
                  dut_in        <= '0;
                  wait_cnt      <= SETTLE_CNT;
                  busy          <= 1'b1;
                  done          <= 1'b0;
                  pass          <= 1'b0;
                  err_count     <= '0;
                  first_err_vld <= 1'b0;
                  table_out     <= '0;
               end
            end

            SETTLE_W: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt <= 4'd1) begin
                  state <= SAMPLE;
               end
            end

            SAMPLE: begin
               table_out[dut_in] <= dut_out;
               err_count         <= err_next;
               if (mismatch && !first_err_vld) begin
                  first_err_idx <= dut_in;
                  first_err_vld <= 1'b1;
               end
               if (dut_in == LAST_IDX) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_next == '0);
               end else begin
                  state    <= LOAD_STATE;
                  dut_in   <= dut_in + 1'b1;
                  wait_cnt <= SETTLE_CNT;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Bench for minterm_sweep_checker: directed fault scenarios plus random truth tables,
// judged against a truth-table model of bcd | a~c~d built from the boolean equation.
module tb_minterm_sweep_checker;

   localparam int MODE_CORRECT = 0;
   localparam int MODE_B_SA0   = 1;
   localparam int MODE_ONE     = 2;
   localparam int MODE_ZERO    = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, start0;
   logic [15:0] fn_table;

   logic        dut_out, busy, done, pass, first_err_vld;
   logic [3:0]  dut_in, first_err_idx;
   logic [4:0]  err_count;
   logic [15:0] table_out;

   logic        dut_out0, busy0, done0, pass0, first_err_vld0;
   logic [3:0]  dut_in0, first_err_idx0;
   logic [4:0]  err_count0;
   logic [15:0] table_out0;

   int assert_count = 0;
   int fail_count   = 0;

   always #5 clk = ~clk;

   assign dut_out  = fn_table[dut_in];
   assign dut_out0 = fn_table[dut_in0];

   minterm_sweep_checker #(.N_IN(4), .EXPECT(16'h9180), .SETTLE(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dut_out(dut_out), .dut_in(dut_in),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .first_err_idx(first_err_idx), .first_err_vld(first_err_vld), .table_out(table_out)
   );

   minterm_sweep_checker #(.N_IN(4), .EXPECT(16'h9180), .SETTLE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .dut_out(dut_out0), .dut_in(dut_in0),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err_count0),
      .first_err_idx(first_err_idx0), .first_err_vld(first_err_vld0), .table_out(table_out0)
   );

   // Truth table of the function under each fault scenario, from the boolean equation.
   function automatic logic [15:0] build_table(input int mode);
      logic [15:0] t;
      logic a, b, c, d;
      t = '0;
      for (int v = 0; v < 16; v++) begin
         a = v[3]; b = v[2]; c = v[1]; d = v[0];
         if (mode == MODE_B_SA0) b = 1'b0;
         case (mode)
            MODE_ONE:  t[v] = 1'b1;
            MODE_ZERO: t[v] = 1'b0;
            default:   t[v] = (b & c & d) | (a & ~c & ~d);
         endcase
      end
      return t;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assert_count++;
      assert (observed === expected) else begin
         fail_count++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Runs one sweep on the SETTLE=1 instance; optionally pokes start while busy.
   task automatic applyStimulus(input logic [15:0] tbl, input bit mid_starts, output int edges);
      fn_table = tbl;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      edges = 0;
      checkOutput("start_busy", 32'(busy), 32'd1);
      checkOutput("start_done_clr", 32'(done), 32'd0);
      checkOutput("start_err_clr", 32'(err_count), 32'd0);
      checkOutput("start_table_clr", 32'(table_out), 32'd0);
      checkOutput("start_vld_clr", 32'(first_err_vld), 32'd0);
      checkOutput("start_pass_clr", 32'(pass), 32'd0);
      while (!done && edges < 200) begin
         @(posedge clk);
         @(negedge clk);
         edges++;
         start = mid_starts && (edges == 5 || edges == 20);
      end
      start = 1'b0;
   endtask

   task automatic checkSweep(input string tag, input logic [15:0] tbl, input int edges);
      logic [15:0] diff;
      int          errs;
      int          first;
      diff  = tbl ^ build_table(MODE_CORRECT);
      errs  = $countones(diff);
      first = -1;
      for (int i = 15; i >= 0; i--) if (diff[i]) first = i;
      $display("[TB] %s: table=%h expected errors=%0d", tag, tbl, errs);
      checkOutput({tag, "_latency"}, 32'(edges), 32'd32);
      checkOutput({tag, "_done"}, 32'(done), 32'd1);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_table"}, 32'(table_out), 32'(tbl));
      checkOutput({tag, "_err_count"}, 32'(err_count), 32'(errs));
      checkOutput({tag, "_pass"}, 32'(pass), 32'(errs == 0));
      checkOutput({tag, "_first_vld"}, 32'(first_err_vld), 32'(first >= 0));
      if (first >= 0) checkOutput({tag, "_first_idx"}, 32'(first_err_idx), 32'(first));
      checkOutput({tag, "_last_vec"}, 32'(dut_in), 32'd15);
   endtask

   initial begin
      int          edges;
      logic [15:0] rnd;

      rst_n    = 1'b0;
      start    = 1'b0;
      start0   = 1'b0;
      fn_table = build_table(MODE_CORRECT);
      #1;
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_dut_in", 32'(dut_in), 32'd0);
      checkOutput("reset_err_count", 32'(err_count), 32'd0);
      checkOutput("reset_table", 32'(table_out), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] golden table %h", build_table(MODE_CORRECT));
      checkOutput("golden_eq", 32'(build_table(MODE_CORRECT)), 32'h9180);

      applyStimulus(build_table(MODE_CORRECT), 1'b0, edges);
      checkSweep("correct", build_table(MODE_CORRECT), edges);

      applyStimulus(build_table(MODE_B_SA0), 1'b0, edges);
      checkSweep("b_sa0", build_table(MODE_B_SA0), edges);

      applyStimulus(build_table(MODE_ONE), 1'b0, edges);
      checkSweep("const1", build_table(MODE_ONE), edges);

      applyStimulus(build_table(MODE_ZERO), 1'b0, edges);
      checkSweep("const0", build_table(MODE_ZERO), edges);

      // Restart from DONE with start pulses landing mid-sweep.
      applyStimulus(build_table(MODE_CORRECT), 1'b1, edges);
      checkSweep("midstart", build_table(MODE_CORRECT), edges);

      // Asynchronous reset in the middle of a sweep.
      fn_table = build_table(MODE_ONE);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (13) @(negedge clk);
      checkOutput("pre_reset_err_nonzero", 32'(err_count != 0), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_busy", 32'(busy), 32'd0);
      checkOutput("async_dut_in", 32'(dut_in), 32'd0);
      checkOutput("async_err_count", 32'(err_count), 32'd0);
      checkOutput("async_table", 32'(table_out), 32'd0);
      checkOutput("async_first_vld", 32'(first_err_vld), 32'd0);
      checkOutput("async_first_idx", 32'(first_err_idx), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("idle_after_reset", 32'({busy, done}), 32'd0);
      applyStimulus(build_table(MODE_CORRECT), 1'b0, edges);
      checkSweep("after_reset", build_table(MODE_CORRECT), edges);

      // SETTLE=0 build: one vector per cycle.
      fn_table = build_table(MODE_CORRECT);
      @(negedge clk);
      start0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start0 = 1'b0;
      edges = 0;
      while (!done0 && edges < 200) begin
         if (edges < 16) checkOutput($sformatf("s0_dut_in_%0d", edges), 32'(dut_in0), 32'(edges));
         @(posedge clk);
         @(negedge clk);
         edges++;
      end
      checkOutput("s0_latency", 32'(edges), 32'd16);
      checkOutput("s0_pass", 32'(pass0), 32'd1);
      checkOutput("s0_table", 32'(table_out0), 32'h9180);
      checkOutput("s0_err_count", 32'(err_count0), 32'd0);
      checkOutput("s0_first_vld", 32'(first_err_vld0), 32'd0);

      for (int k = 0; k < 4; k++) begin
         rnd = 16'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         applyStimulus(rnd, 1'($urandom_range(0, 1)), edges);
         checkSweep($sformatf("random%0d", k), rnd, edges);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
